// File: rtl/pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_ctrl
// Brief    : PLL reset/lock sequencer: drives PLL reset/power-down, qualifies
//            lock, relocks on loss, fails after MAX_RETRY lock attempts.
//            Optional lock-loss counter: define PLL_LOCK_CTRL_LOSS_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_ctrl #(
    parameter int RST_CYCLES    = 4,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRY     = 3
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       pll_lock,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       pll_pwd,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

    localparam int c_MAX_AB  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int c_MAX_CNT = (c_MAX_AB > RST_CYCLES) ? c_MAX_AB : RST_CYCLES;
    localparam int c_TIMER_W = $clog2(c_MAX_CNT + 1);
    localparam int c_RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [c_TIMER_W-1:0] c_RST_LAST    = c_TIMER_W'(RST_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_LOCK_LAST   = c_TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_STABLE_LAST = c_TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX   = c_RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_TIMER_W-1:0]   w_timer_next;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [c_RETRY_W-1:0]   w_retry_next;
    logic                   r_lock_meta;
    logic                   r_lock_s;
    logic                   w_attempt_fail;
    logic                   w_loss_event;

    always_comb begin
        w_next_state   = r_state;
        w_timer_next   = r_timer;
        w_retry_next   = r_retry;
        w_attempt_fail = 1'b0;
        w_loss_event   = 1'b0;

        case (r_state)
            ST_RESET: begin
                w_timer_next = r_timer + 1'b1;
                if (r_timer == c_RST_LAST)
                    w_next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                w_timer_next = r_timer + 1'b1;
                if (r_lock_s)
                    w_next_state = ST_STABLE;
                else if (r_timer == c_LOCK_LAST)
                    w_attempt_fail = 1'b1;
            end
            ST_STABLE: begin
                w_timer_next = r_timer + 1'b1;
                if (!r_lock_s)
                    w_attempt_fail = 1'b1;
                else if (r_timer == c_STABLE_LAST)
                    w_next_state = ST_RUN;
            end
            ST_RUN: begin
                if (!r_lock_s) begin
                    w_next_state = ST_RESET;
                    w_loss_event = 1'b1;
                end
            end
            ST_FAIL: begin
                w_next_state = ST_FAIL;
            end
            default: begin
                w_next_state = ST_RESET;
            end
        endcase

        if (w_attempt_fail) begin
            w_retry_next = r_retry + 1'b1;
            w_next_state = (w_retry_next == c_RETRY_MAX) ? ST_FAIL : ST_RESET;
        end

        if (w_next_state == ST_RUN && r_state != ST_RUN)
            w_retry_next = '0;

        // A relock request overrides everything, including a same-cycle lock loss.
        if (relock_req) begin
            w_next_state = ST_RESET;
            w_retry_next = '0;
            w_loss_event = 1'b0;
        end

        if (relock_req || w_next_state != r_state)
            w_timer_next = '0;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= ST_RESET;
            r_timer     <= '0;
            r_retry     <= '0;
            pll_rst     <= 1'b1;
            pll_pwd     <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            r_lock_meta <= pll_lock;
            r_lock_s    <= r_lock_meta;
            r_state     <= w_next_state;
            r_timer     <= w_timer_next;
            r_retry     <= w_retry_next;
            pll_rst     <= (w_next_state == ST_RESET) || (w_next_state == ST_FAIL);
            pll_pwd     <= (w_next_state == ST_FAIL);
            ready       <= (w_next_state == ST_RUN);
            fail        <= (w_next_state == ST_FAIL);
        end
    end

    assign state = r_state;

`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    logic [7:0] r_loss_cnt;

    // Saturating; deliberately untouched by relock_req.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)
            r_loss_cnt <= 8'd0;
        else if (w_loss_event && r_loss_cnt != 8'hFF)
            r_loss_cnt <= r_loss_cnt + 8'd1;
    end

    assign loss_cnt = r_loss_cnt;
`else
    logic w_unused_loss;
    assign w_unused_loss = w_loss_event;
    assign loss_cnt      = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_ctrl
// Brief    : Directed and randomized checks of pll_lock_ctrl against a
//            cycle-count reference model of the lock sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_ctrl;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 100;
    localparam int STABLE_CYCLES = 16;
    localparam int MAX_RETRY     = 3;

    localparam int P_RESET  = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
    localparam int LOSS_ONE = 1;
    localparam int LOSS_SAT = 255;
`else
    localparam int LOSS_ONE = 0;
    localparam int LOSS_SAT = 0;
`endif

    // {state, pll_rst, pll_pwd, ready, fail, loss_cnt} at reset
    localparam logic [31:0] RESET_VEC = {17'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

    logic       sys_clk = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       relock_req;
    logic       pll_rst;
    logic       pll_pwd;
    logic       ready;
    logic       fail;
    logic [2:0] state;
    logic [7:0] loss_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: phase, cycles spent in phase, failed attempts, losses
    int     m_phase;
    int     m_cnt;
    int     m_retry;
    int     m_loss;
    bit [1:0] m_sync;

    pll_lock_ctrl #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .pll_pwd   (pll_pwd),
        .ready     (ready),
        .fail      (fail),
        .state     (state),
        .loss_cnt  (loss_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_RESET;
        m_cnt   = 0;
        m_retry = 0;
        m_loss  = 0;
        m_sync  = 2'b00;
    endtask

    // Advance the model by one rising edge using the inputs seen at that edge.
    task automatic model_step();
        bit ls;
        int nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls     = m_sync[1];
        m_sync = {m_sync[0], pll_lock};
        nxt    = m_phase;
        if (relock_req) begin
            nxt     = P_RESET;
            m_retry = 0;
        end else begin
            case (m_phase)
                P_RESET:  if (m_cnt + 1 >= RST_CYCLES) nxt = P_WAIT;
                P_WAIT: begin
                    if (ls) nxt = P_STABLE;
                    else if (m_cnt + 1 >= LOCK_TIMEOUT) begin
                        m_retry++;
                        nxt = (m_retry >= MAX_RETRY) ? P_FAIL : P_RESET;
                    end
                end
                P_STABLE: begin
                    if (!ls) begin
                        m_retry++;
                        nxt = (m_retry >= MAX_RETRY) ? P_FAIL : P_RESET;
                    end else if (m_cnt + 1 >= STABLE_CYCLES) begin
                        nxt     = P_RUN;
                        m_retry = 0;
                    end
                end
                P_RUN: begin
                    if (!ls) begin
                        nxt = P_RESET;
                        if (m_loss < 255) m_loss++;
                    end
                end
                default: nxt = m_phase;
            endcase
        end
        m_cnt   = (relock_req || nxt != m_phase) ? 0 : m_cnt + 1;
        m_phase = nxt;
    endtask

    function automatic logic [31:0] exp_vec();
        logic [7:0] l;
`ifdef PLL_LOCK_CTRL_LOSS_CNT_EN
        l = 8'(m_loss);
`else
        l = 8'd0;
`endif
        return {17'd0, 3'(m_phase),
                (m_phase == P_RESET) || (m_phase == P_FAIL),
                m_phase == P_FAIL, m_phase == P_RUN, m_phase == P_FAIL, l};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {17'd0, state, pll_rst, pll_pwd, ready, fail, loss_cnt};
    endfunction

    // Drive at the falling edge, step model at rising edge, compare at next falling edge.
    task automatic tick(input bit lk, input bit rr);
        pll_lock   = lk;
        relock_req = rr;
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check("outputs", dut_vec(), exp_vec());
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            tick(1'b1, 1'b0);
            n++;
        end
        check(tag, 32'(ready), 32'd1);
    endtask

    task automatic lose_lock();
        int n;
        n = 0;
        while (ready && n < 10) begin
            tick(1'b0, 1'b0);
            n++;
        end
        check("loss_ready_fall", 32'(n), 32'd3);
    endtask

    task automatic glitch_in_stable();
        int n;
        n = 0;
        while (state != 3'd2 && n < 50) begin
            tick(1'b1, 1'b0);
            n++;
        end
        check("reach_stable", 32'(state), 32'd2);
        tick(1'b0, 1'b0);
        n = 1;
        while (state != 3'd0 && n < 10) begin
            tick(1'b1, 1'b0);
            n++;
        end
        check("glitch_to_reset", 32'(n), 32'd3);
    endtask

    task automatic count_to_fail(input string tag, input int expected);
        int  n;
        bit  saw_ready;
        n = 0;
        saw_ready = 1'b0;
        while (!fail && n < 400) begin
            tick(1'b0, 1'b0);
            n++;
            if (ready) saw_ready = 1'b1;
        end
        check(tag, 32'(n), 32'(expected));
        check("no_ready_before_fail", 32'(saw_ready), 32'd0);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check(tag, dut_vec(), RESET_VEC);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int run;
        bit lv;

        rst_n      = 1'b0;
        pll_lock   = 1'b0;
        relock_req = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check("reset_values", dut_vec(), RESET_VEC);
        rst_n = 1'b1;

        // Clean bring-up
        n = 0;
        while (pll_rst && n < 20) begin
            tick(1'b0, 1'b0);
            n++;
        end
        check("rst_pulse_len", 32'(n), 32'(RST_CYCLES));
        repeat (10) tick(1'b0, 1'b0);
        n = 0;
        do begin
            tick(1'b1, 1'b0);
            n++;
        end while (!ready && n < 100);
        // includes the sampling edge, two synchroniser stages, STABLE_CYCLES
        check("lock_to_ready", 32'(n), 32'(1 + 2 + STABLE_CYCLES));
        check("run_state", 32'(state), 32'(P_RUN));
        check("run_fail", 32'(fail), 32'd0);

        // Lock loss in RUN
        lose_lock();
        n = 0;
        while (pll_rst && n < 20) begin
            n++;
            tick(1'b1, 1'b0);
        end
        check("loss_rst_pulse", 32'(n), 32'(RST_CYCLES));
        check("loss_cnt_one", 32'(loss_cnt), 32'(LOSS_ONE));
        wait_ready("relock_ready");

        // relock_req coincident with lock_s fall: not counted as a loss
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("relock_vs_loss_state", 32'(state), 32'(P_RESET));
        check("relock_vs_loss_cnt", 32'(loss_cnt), 32'(LOSS_ONE));

        // No lock at all -> FAIL after MAX_RETRY attempts
        async_reset("async_reset_values");
        count_to_fail("fail_time", MAX_RETRY * (RST_CYCLES + LOCK_TIMEOUT));
        check("fail_state", 32'(state), 32'(P_FAIL));
        check("fail_pwd_rst", 32'({pll_pwd, pll_rst, ready}), 32'b110);

        tick(1'b0, 1'b1);
        check("relock_from_fail", 32'({state, fail, pll_pwd, pll_rst}), 32'b000_0_0_1);

        // Glitch in STABLE, recover to RUN (retry cleared), then full 3 attempts to FAIL
        glitch_in_stable();
        wait_ready("ready_after_glitch");
        lose_lock();
        count_to_fail("fail_time_after_run", MAX_RETRY * (RST_CYCLES + LOCK_TIMEOUT));
        tick(1'b0, 1'b1);

        // Glitch leaves one attempt consumed: only two more to FAIL
        glitch_in_stable();
        count_to_fail("fail_time_after_glitch", (MAX_RETRY - 1) * (RST_CYCLES + LOCK_TIMEOUT));
        tick(1'b0, 1'b1);

        // rst_n mid WAIT_LOCK
        repeat (RST_CYCLES + 50) tick(1'b0, 1'b0);
        check("in_wait_lock", 32'(state), 32'(P_WAIT));
        async_reset("reset_mid_wait");
        repeat (RST_CYCLES) tick(1'b0, 1'b0);
        check("restart_wait", 32'({state, pll_rst}), 32'({3'd1, 1'b0}));
        wait_ready("restart_ready");

        // Loss counter saturation
        repeat (300) begin
            n = 0;
            while (!ready && n < 60) begin
                tick(1'b1, 1'b0);
                n++;
            end
            n = 0;
            while (ready && n < 10) begin
                tick(1'b0, 1'b0);
                n++;
            end
        end
        check("loss_cnt_sat", 32'(loss_cnt), 32'(LOSS_SAT));

        // Randomized lock behaviour with occasional relock and reset
        for (int i = 0; i < 3000; ) begin
            run = $urandom_range(1, 60);
            lv  = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < run; j++) begin
                if ($urandom_range(0, 399) == 0)
                    async_reset("rand_async_reset");
                tick(lv, $urandom_range(0, 79) == 0);
                i++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
